// File: rtl/keycode_bank_pkg.sv
// Shared constants and FSM state type for the keycode bank.
package keycode_bank_pkg;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVF     = 1;
    localparam int STAT_PENDING = 3;
    localparam int CNT_LSB      = 8;

    typedef enum logic [1:0] {
        IDLE,
        REL,
        PRS
    } state_t;

endpackage

// File: rtl/keycode_bank_if.sv
// Avalon-MM slave bus plus the event valid/ready port of the keycode bank.
interface keycode_bank_if #(
    parameter int ADDR_W = 4,
    parameter int KEY_W  = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              evt_valid;
    logic              evt_ready;
    logic [KEY_W-1:0]  evt_code;
    logic              evt_press;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, evt_ready,
        input  avs_readdata, evt_valid, evt_code, evt_press
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, evt_ready,
        output avs_readdata, evt_valid, evt_code, evt_press
    );
endinterface

// File: rtl/keycode_evt_fifo.sv
// Small event FIFO; the head is read straight from storage registers,
// so nothing on the output side depends combinationally on pop.
module keycode_evt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/keycode_bank.sv
// Shadow/committed keycode registers with an atomic commit that diffs the
// new set against the old one and queues release then press events.
module keycode_bank
    import keycode_bank_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int KEY_W     = 8,
    parameter int EVT_DEPTH = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    keycode_bank_if.slave           bus,
    output logic [NUM_CH*KEY_W-1:0] keycode_export,
    output logic                    irq
);
    localparam int CTRL_ADDR = NUM_CH;
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W     = $clog2(EVT_DEPTH) + 1;

    logic [KEY_W-1:0] shadow    [NUM_CH];
    logic [KEY_W-1:0] committed [NUM_CH];
    logic [KEY_W-1:0] old_set   [NUM_CH];
    logic [KEY_W-1:0] new_set   [NUM_CH];

    state_t           state, next_state;
    logic [IDX_W-1:0] idx;
    logic             pending, overflow, irq_en;
    logic [31:0]      readdata, rd_mux;

    logic             ctrl_wr, commit_req, busy, scan_last, scan_end, start_scan, scan_prs;
    logic [KEY_W-1:0] cur;
    logic [NUM_CH-1:0] eq_other, eq_prior;
    logic             fifo_push, fifo_full, fifo_empty, fifo_ovf;
    logic [KEY_W:0]   fifo_din, fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_bits;

    assign ctrl_wr    = bus.avs_write && (bus.avs_address == ADDR_W'(CTRL_ADDR));
    assign commit_req = ctrl_wr && bus.avs_writedata[CTRL_COMMIT];
    assign busy       = (state != IDLE);
    assign scan_prs   = (state == PRS);
    assign scan_last  = (idx == IDX_W'(NUM_CH - 1));
    assign scan_end   = scan_prs && scan_last;
    // A commit that lands on the final scan cycle is folded into the restart.
    assign start_scan = (commit_req && !busy) || (scan_end && (pending || commit_req));

    // Membership compare: the slot under scan against the other set and against earlier slots of its own set.
    always_comb begin
        cur      = '0;
        eq_other = '0;
        eq_prior = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (IDX_W'(j) == idx) cur = scan_prs ? new_set[j] : old_set[j];
        end
        for (int j = 0; j < NUM_CH; j++) begin
            eq_other[j] = ((scan_prs ? old_set[j] : new_set[j]) == cur);
            eq_prior[j] = (IDX_W'(j) < idx) && ((scan_prs ? new_set[j] : old_set[j]) == cur);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_push  = 1'b0;
        fifo_din   = {cur, scan_prs};
        case (state)
            IDLE: if (start_scan) next_state = REL;
            REL: begin
                fifo_push = (cur != '0) && !(|eq_other) && !(|eq_prior);
                if (scan_last) next_state = PRS;
            end
            PRS: begin
                fifo_push = (cur != '0) && !(|eq_other) && !(|eq_prior);
                if (scan_last) next_state = start_scan ? REL : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            idx <= '0;
            for (int j = 0; j < NUM_CH; j++) begin
                committed[j] <= '0;
                old_set[j]   <= '0;
                new_set[j]   <= '0;
            end
        end else begin
            if (start_scan || (busy && scan_last)) idx <= '0;
            else if (busy)                          idx <= idx + IDX_W'(1);
            if (start_scan) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    committed[j] <= shadow[j];
                    old_set[j]   <= committed[j];
                    new_set[j]   <= shadow[j];
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int j = 0; j < NUM_CH; j++) shadow[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (bus.avs_write && (bus.avs_address == ADDR_W'(j)))
                    shadow[j] <= bus.avs_writedata[KEY_W-1:0];
            end
        end
    end

    // A lost event outranks a simultaneous clear so it is never hidden.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (scan_end)                 pending <= 1'b0;
            else if (commit_req && busy)  pending <= 1'b1;
            if (fifo_ovf)                                          overflow <= 1'b1;
            else if (ctrl_wr && bus.avs_writedata[CTRL_CLR_OVF])   overflow <= 1'b0;
            if (ctrl_wr) irq_en <= bus.avs_writedata[CTRL_IRQ_EN];
            irq      <= irq_en && !fifo_empty;
            readdata <= bus.avs_read ? rd_mux : '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (bus.avs_address == ADDR_W'(j)) rd_mux[KEY_W-1:0] = shadow[j];
        end
        if (bus.avs_address == ADDR_W'(CTRL_ADDR)) begin
            rd_mux[STAT_BUSY]            = busy;
            rd_mux[STAT_OVF]             = overflow;
            rd_mux[CTRL_IRQ_EN]          = irq_en;
            rd_mux[STAT_PENDING]         = pending;
            rd_mux[CNT_LSB +: CNT_W]     = fifo_count;
        end
    end

    always_comb begin
        keycode_export = '0;
        for (int j = 0; j < NUM_CH; j++) keycode_export[j*KEY_W +: KEY_W] = committed[j];
    end

    keycode_evt_fifo #(
        .WIDTH (KEY_W + 1),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (fifo_push),
        .din      (fifo_din),
        .full     (fifo_full),
        .pop      (bus.evt_ready),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    assign bus.avs_readdata = readdata;
    assign bus.evt_valid    = !fifo_empty;
    assign bus.evt_code     = fifo_dout[KEY_W:1];
    assign bus.evt_press    = fifo_dout[0];
    assign unused_bits      = ^{bus.avs_writedata[31:KEY_W], fifo_full};

endmodule

// File: tb/tb_keycode_bank.sv
// Directed bench for keycode_bank: commit/diff vectors plus overflow,
// pending-commit, irq and async-reset sequences.
module tb_keycode_bank;

    localparam int NUM_CH = 6;
    localparam int KEY_W  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam logic [3:0] CTRL = 4'd6;

    typedef struct packed {
        logic [47:0] slots;
        logic [3:0]  n_evt;
        logic [26:0] evts;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] keycode_export;
    logic        irq;
    int          tests_run = 0;
    int          tests_failed = 0;
    vec_t        tbl [6];
    logic [31:0] d;

    keycode_bank_if #(.ADDR_W(ADDR_W), .KEY_W(KEY_W)) bus ();

    keycode_bank #(
        .NUM_CH    (NUM_CH),
        .KEY_W     (KEY_W),
        .EVT_DEPTH (DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .bus            (bus),
        .keycode_export (keycode_export),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
        bus.avs_address   = a;
        bus.avs_writedata = wd;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] rd);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        rd = bus.avs_readdata;
    endtask

    task automatic wait_idle(input string name, output logic [31:0] rd);
        int k;
        k  = 0;
        rd = 32'h1;
        while (rd[0] && k < 40) begin
            bus_read(CTRL, rd);
            k++;
        end
        checkOutput(name, {63'b0, rd[0]}, 64'h0);
    endtask

    task automatic pop_event(input string name, input logic [8:0] exp_evt);
        checkOutput({name, "_valid"}, {63'b0, bus.evt_valid}, 64'h1);
        checkOutput({name, "_evt"}, {55'b0, bus.evt_code, bus.evt_press}, {55'b0, exp_evt});
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
    endtask

    task automatic write_slots(input logic [47:0] s);
        for (int i = 0; i < NUM_CH; i++) bus_write(4'(i), {24'b0, s[i*8 +: 8]});
    endtask

    task automatic applyStimulus(input vec_t v, input int id);
        logic [31:0] rd;
        write_slots(v.slots);
        bus_write(CTRL, 32'h1);
        checkOutput($sformatf("v%0d_export", id), {16'b0, keycode_export}, {16'b0, v.slots});
        wait_idle($sformatf("v%0d_idle", id), rd);
        checkOutput($sformatf("v%0d_count", id), {56'b0, rd[15:8]}, {60'b0, v.n_evt});
        for (int k = 0; k < int'(v.n_evt); k++)
            pop_event($sformatf("v%0d_e%0d", id, k), v.evts[k*9 +: 9]);
        checkOutput($sformatf("v%0d_drained", id), {63'b0, bus.evt_valid}, 64'h0);
    endtask

    function automatic vec_t mkv(input logic [47:0] s, input int n,
                                 input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
        vec_t v;
        v.slots = s;
        v.n_evt = 4'(n);
        v.evts  = {e2, e1, e0};
        return v;
    endfunction

    initial begin
        // events are {code, press}: press 0x04 = 9'h009, release 0x04 = 9'h008
        tbl[0] = mkv(48'h000000000705, 2, 9'h008, 9'h00F, 9'h000);
        tbl[1] = mkv(48'h000000000000, 2, 9'h00A, 9'h00E, 9'h000);
        tbl[2] = mkv(48'h000000090909, 1, 9'h013, 9'h000, 9'h000);
        tbl[3] = mkv(48'h090000000000, 0, 9'h000, 9'h000, 9'h000);
        tbl[4] = mkv(48'h09000A0B000A, 2, 9'h015, 9'h017, 9'h000);
        tbl[5] = mkv(48'h000000000000, 3, 9'h014, 9'h016, 9'h012);

        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0; bus.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        checkOutput("rst_export", {16'b0, keycode_export}, 64'h0);
        checkOutput("rst_valid", {63'b0, bus.evt_valid}, 64'h0);
        checkOutput("rst_irq", {63'b0, irq}, 64'h0);
        bus_read(CTRL, d);
        checkOutput("rst_ctrl", {32'b0, d}, 64'h0);

        // first commit: exact busy window and immediate export update
        write_slots(48'h000000000504);
        checkOutput("shadow_only_export", {16'b0, keycode_export}, 64'h0);
        bus_read(4'd1, d);
        checkOutput("slot1_read", {32'b0, d}, 64'h5);
        bus_write(CTRL, 32'h1);
        checkOutput("c0_export", {16'b0, keycode_export}, 64'h000000000504);
        repeat (11) @(negedge clk);
        bus_read(CTRL, d);
        checkOutput("c0_busy_last", {32'b0, d}, 64'h0201);
        bus_read(CTRL, d);
        checkOutput("c0_idle", {32'b0, d}, 64'h0200);
        pop_event("c0_e0", 9'h009);
        pop_event("c0_e1", 9'h00B);

        for (int i = 0; i < 6; i++) applyStimulus(tbl[i], i + 1);

        // overflow with a 4-deep FIFO, then plain clear
        write_slots(48'h060504030201);
        bus_write(CTRL, 32'h1);
        wait_idle("ovf_idle", d);
        checkOutput("ovf_ctrl", {32'b0, d}, 64'h0402);
        bus_write(CTRL, 32'h2);
        bus_read(CTRL, d);
        checkOutput("ovf_cleared", {32'b0, d}, 64'h0400);
        pop_event("ovf_e0", 9'h003);
        pop_event("ovf_e1", 9'h005);
        pop_event("ovf_e2", 9'h007);
        pop_event("ovf_e3", 9'h009);

        write_slots(48'h000000000000);
        bus_write(CTRL, 32'h1);
        wait_idle("ovf2_idle", d);
        checkOutput("ovf2_ctrl", {32'b0, d}, 64'h0402);
        pop_event("ovf2_e0", 9'h002);
        pop_event("ovf2_e1", 9'h004);
        pop_event("ovf2_e2", 9'h006);
        pop_event("ovf2_e3", 9'h008);

        // commit and clear-overflow in one write
        bus_write(4'd0, 32'h07);
        bus_write(CTRL, 32'h3);
        wait_idle("cc_idle", d);
        checkOutput("cc_ctrl", {32'b0, d}, 64'h0100);
        pop_event("cc_e0", 9'h00F);

        // pending commit: second commit 2 cycles later, shadow edit mid-scan
        bus_write(4'd0, 32'h11);
        bus_write(CTRL, 32'h1);
        @(negedge clk);
        bus_write(CTRL, 32'h1);
        bus_write(4'd1, 32'h12);
        bus_read(CTRL, d);
        checkOutput("pend_set", {32'b0, d}, 64'h0109);
        repeat (7) @(negedge clk);
        bus_read(CTRL, d);
        checkOutput("pend_scan_end", {32'b0, d}, 64'h0209);
        bus_read(CTRL, d);
        checkOutput("pend_restart", {32'b0, d}, 64'h0201);
        wait_idle("pend_idle", d);
        checkOutput("pend_count", {56'b0, d[15:8]}, 64'h3);
        checkOutput("pend_export", {16'b0, keycode_export}, 64'h000000001211);
        pop_event("pend_e0", 9'h00E);
        pop_event("pend_e1", 9'h023);
        pop_event("pend_e2", 9'h025);

        // irq rises a cycle after the push, falls a cycle after the drain
        bus_write(4'd2, 32'h13);
        bus_write(CTRL, 32'h5);
        repeat (9) @(negedge clk);
        checkOutput("irq_valid", {63'b0, bus.evt_valid}, 64'h1);
        checkOutput("irq_lag", {63'b0, irq}, 64'h0);
        @(negedge clk);
        checkOutput("irq_high", {63'b0, irq}, 64'h1);
        checkOutput("irq_evt", {55'b0, bus.evt_code, bus.evt_press}, 64'h027);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        checkOutput("irq_empty", {63'b0, bus.evt_valid}, 64'h0);
        checkOutput("irq_hold", {63'b0, irq}, 64'h1);
        @(negedge clk);
        checkOutput("irq_low", {63'b0, irq}, 64'h0);
        bus.evt_ready = 1'b0;
        wait_idle("irq_idle", d);

        // async reset mid-scan
        bus_write(4'd3, 32'h14);
        bus_write(CTRL, 32'h5);
        repeat (11) @(negedge clk);
        checkOutput("pre_rst_irq", {63'b0, irq}, 64'h1);
        checkOutput("pre_rst_export", {16'b0, keycode_export}, 64'h000014131211);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_export", {16'b0, keycode_export}, 64'h0);
        checkOutput("arst_valid", {63'b0, bus.evt_valid}, 64'h0);
        checkOutput("arst_evt", {55'b0, bus.evt_code, bus.evt_press}, 64'h0);
        checkOutput("arst_irq", {63'b0, irq}, 64'h0);
        checkOutput("arst_readdata", {32'b0, bus.avs_readdata}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(CTRL, d);
        checkOutput("post_rst_ctrl", {32'b0, d}, 64'h0);
        bus_read(4'd3, d);
        checkOutput("post_rst_slot3", {32'b0, d}, 64'h0);
        repeat (14) @(negedge clk);
        checkOutput("post_rst_valid", {63'b0, bus.evt_valid}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
